// File: rtl/apb_pkg.sv
// Shared definitions for the APB memory slave: FSM states, lane-shift
// helper and the legal wait-state range.
package apb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   // Upper bound of WAIT_CYCLES; the wait counter is sized to hold it.
   localparam int WAIT_MAX = 15;
   localparam int WCNT_W   = 4;

   // Number of low address bits that select a byte inside one data word.
   function automatic int lane_shift(input int data_w);
      case (data_w)
         8:       return 0;
         16:      return 1;
         default: return 2;
      endcase
   endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W storage with per-byte write enables, synchronous clear
// and combinational read.
module apb_mem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int IDX_W  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [IDX_W-1:0]    idx,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] strb,
   output logic [DATA_W-1:0]   rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Clear on reset, otherwise merge strobed byte lanes into the addressed word.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: every word is cleared on reset so storage reads back as zero
         // before software writes it; this is intentional, not an oversight.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (strb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Guard keeps a non-power-of-two DEPTH from reading past the array end.
   assign rdata = ({1'b0, idx} < (IDX_W+1)'(DEPTH)) ? mem[idx] : '0;

endmodule

// File: rtl/apb_mem_slave.sv
// Parametrised APB4 slave memory: byte strobes, wait states, error
// responses for out-of-range / misaligned accesses, abort tolerance.
module apb_mem_slave
   import apb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                pclk,
   input  logic                prst,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [ADDR_W-1:0]   paddr,
   input  logic [DATA_W-1:0]   pwdata,
   input  logic [DATA_W/8-1:0] pstrb,
   output logic                pready,
   output logic                pslverr,
   output logic [DATA_W-1:0]   prdata
);

   localparam int NB    = DATA_W / 8;
   localparam int SHIFT = lane_shift(DATA_W);
   localparam int IDX_W = $clog2(DEPTH);

   state_t              state;
   logic [WCNT_W-1:0]   wcnt;
   logic                hold_write;
   logic [ADDR_W-1:0]   hold_addr;
   logic [DATA_W-1:0]   hold_wdata;
   logic [NB-1:0]       hold_strb;

   logic [ADDR_W-1:0]   word_idx;
   logic                err;
   logic                done;
   logic                mem_we;
   logic [DATA_W-1:0]   rd_word;

   // Decode purely from the captured address so bus changes in ACCESS are ignored.
   assign word_idx = hold_addr >> SHIFT;
   assign err      = (word_idx >= ADDR_W'(DEPTH)) ||
                     ((hold_addr & ADDR_W'(NB-1)) != '0);

   // Completion: a valid access phase once the wait count has reached its limit.
   assign done   = (state == ACCESS) && psel && penable &&
                   (wcnt == WCNT_W'(WAIT_CYCLES));
   assign mem_we = done && hold_write && !err;

   // Setup capture, wait counting and abort handling.
   always_ff @(posedge pclk) begin
      if (prst) begin
         // NOTE: non-blocking assignments for all state, so every register
         // samples the pre-edge values regardless of statement order.
         state      <= IDLE;
         wcnt       <= '0;
         hold_write <= 1'b0;
         hold_addr  <= '0;
         hold_wdata <= '0;
         hold_strb  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (psel && !penable) begin
                  state      <= ACCESS;
                  wcnt       <= '0;
                  hold_write <= pwrite;
                  hold_addr  <= paddr;
                  hold_wdata <= pwdata;
                  hold_strb  <= pstrb;
               end
            end
            ACCESS: begin
               if (psel && penable) begin
                  if (wcnt < WCNT_W'(WAIT_CYCLES)) wcnt <= wcnt + 1'b1;
                  else                             state <= IDLE;
               end else begin
                  state <= IDLE;   // protocol abort: drop the transfer
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   apb_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_mem (
      .clk   (pclk),
      .rst   (prst),
      .we    (mem_we),
      .idx   (word_idx[IDX_W-1:0]),
      .wdata (hold_wdata),
      .strb  (hold_strb),
      .rdata (rd_word)
   );

   assign pready  = done;
   assign pslverr = done && err;
   assign prdata  = (done && !hold_write && !err) ? rd_word : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: two instances (WAIT_CYCLES 0 and 3) driven by a
// transaction-level driver that predicts each cycle's outputs from a word
// array model; a negedge process compares every cycle.
module tb_apb_mem_slave;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int DEP = 16;

   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   logic [1:0]    prst, psel, penable, pwrite, pready, pslverr;
   logic [AW-1:0] paddr  [2];
   logic [DW-1:0] pwdata [2];
   logic [DW-1:0] prdata [2];
   logic [3:0]    pstrb  [2];

   logic [1:0]    exp_pready, exp_pslverr;
   logic [DW-1:0] exp_prdata [2];
   logic [DW-1:0] mdl [2][DEP];

   int  n_checks = 0;
   int  n_err    = 0;
   bit  run      = 1'b0;

   apb_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYCLES(0)) u_dut0 (
      .pclk(pclk), .prst(prst[0]), .psel(psel[0]), .penable(penable[0]),
      .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
      .pready(pready[0]), .pslverr(pslverr[0]), .prdata(prdata[0]));

   apb_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYCLES(3)) u_dut3 (
      .pclk(pclk), .prst(prst[1]), .psel(psel[1]), .penable(penable[1]),
      .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
      .pready(pready[1]), .pslverr(pslverr[1]), .prdata(prdata[1]));

   task automatic check(input string name, input int k,
                        input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d @%0t: got %h expected %h", name, k, $time, got, exp);
      end
   endtask

   // Every cycle, both instances' outputs against the predicted values.
   always @(negedge pclk) begin
      if (run) begin
         for (int k = 0; k < 2; k++) begin
            check("pready",  k, {31'b0, pready[k]},  {31'b0, exp_pready[k]});
            check("pslverr", k, {31'b0, pslverr[k]}, {31'b0, exp_pslverr[k]});
            check("prdata",  k, prdata[k], exp_prdata[k]);
         end
      end
   end

   function automatic int wait_of(input int k);
      return (k == 0) ? 0 : 3;
   endfunction

   task automatic set_exp(input int k, input bit rdy, input bit err, input logic [31:0] d);
      exp_pready[k]  = rdy;
      exp_pslverr[k] = err;
      exp_prdata[k]  = d;
   endtask

   task automatic clear_model(input int k);
      for (int i = 0; i < DEP; i++) mdl[k][i] = '0;
   endtask

   task automatic idle(input int k, input int n);
      psel[k] = 1'b0; penable[k] = 1'b0;
      set_exp(k, 1'b0, 1'b0, '0);
      repeat (n) begin
         @(posedge pclk); #1;
      end
   endtask

   // One APB transfer. abort_at = access cycle at which psel drops (-1: none).
   // rst_done asserts prst during the completion cycle. rd/len report the
   // observed read data and setup-to-pready length (0 if pready never rose).
   task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       input int abort_at, input bit rst_done,
                       output logic [31:0] rd, output int len);
      int   w;
      bit   err;
      int   idx;
      bit   done;
      logic [31:0] word;
      w   = wait_of(k);
      err = (addr >= 32'(DEP*4)) || (addr[1:0] != 2'b00);
      idx = int'(addr >> 2);
      rd  = '0;
      len = 0;
      psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
      paddr[k] = addr; pwdata[k] = data; pstrb[k] = strb;
      set_exp(k, 1'b0, 1'b0, '0);
      @(posedge pclk); #1;
      for (int c = 0; c <= w; c++) begin
         penable[k] = 1'b1;
         paddr[k]   = $urandom;
         pwdata[k]  = $urandom;
         pstrb[k]   = 4'($urandom);
         if (c == abort_at) begin
            psel[k] = 1'b0;
            set_exp(k, 1'b0, 1'b0, '0);
            @(posedge pclk); #1;
            break;
         end
         done = (c == w);
         if (done) begin
            word = (!wr && !err) ? mdl[k][idx] : 32'h0;
            set_exp(k, 1'b1, err, word);
            if (rst_done) prst[k] = 1'b1;
         end else begin
            set_exp(k, 1'b0, 1'b0, '0);
         end
         @(negedge pclk);
         if (pready[k] && len == 0) len = c + 2;
         if (done) rd = prdata[k];
         @(posedge pclk);
         if (done) begin
            if (rst_done) clear_model(k);
            else if (wr && !err) begin
               word = mdl[k][idx];
               for (int b = 0; b < 4; b++)
                  if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
               mdl[k][idx] = word;
            end
         end
         #1;
         prst[k] = 1'b0;
      end
      psel[k] = 1'b0; penable[k] = 1'b0;
      set_exp(k, 1'b0, 1'b0, '0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int          len;
      prst = 2'b11; psel = '0; penable = '0; pwrite = '0;
      for (int k = 0; k < 2; k++) begin
         paddr[k] = '0; pwdata[k] = '0; pstrb[k] = '0;
         set_exp(k, 1'b0, 1'b0, '0);
         clear_model(k);
      end
      repeat (2) @(posedge pclk);
      #1;
      prst = 2'b00;
      run  = 1'b1;

      // ---- WAIT_CYCLES = 0 instance: directed ----
      xfer(0, 0, 32'h00, 0, 0, -1, 0, rd, len);
      check("lit_rd_idx0_after_reset", 0, rd, 32'h0);
      xfer(0, 1, 32'h08, 32'hDEADBEEF, 4'hF, -1, 0, rd, len);
      check("lit_wr_len", 0, len, 2);
      xfer(0, 0, 32'h08, 0, 0, -1, 0, rd, len);
      check("lit_rd_deadbeef", 0, rd, 32'hDEADBEEF);
      xfer(0, 1, 32'h08, 32'h11223344, 4'h5, -1, 0, rd, len);
      xfer(0, 0, 32'h08, 0, 0, -1, 0, rd, len);
      check("lit_partial_strobe", 0, rd, 32'hDE22BE44);
      xfer(0, 1, 32'h40, 32'hFFFFFFFF, 4'hF, -1, 0, rd, len);
      xfer(0, 0, 32'h00, 0, 0, -1, 0, rd, len);
      check("lit_oor_write_no_alias", 0, rd, 32'h0);
      xfer(0, 0, 32'h06, 0, 0, -1, 0, rd, len);
      check("lit_misaligned_rd", 0, rd, 32'h0);
      xfer(0, 1, 32'h0C, 32'h55AA55AA, 4'hF, 0, 0, rd, len);
      check("lit_abort_no_ready", 0, len, 0);
      xfer(0, 0, 32'h0C, 0, 0, -1, 0, rd, len);
      check("lit_abort_unchanged", 0, rd, 32'h0);
      xfer(0, 1, 32'h0C, 32'h0BADF00D, 4'hF, -1, 0, rd, len);
      xfer(0, 0, 32'h0C, 0, 0, -1, 0, rd, len);
      check("lit_after_abort", 0, rd, 32'h0BADF00D);
      xfer(0, 1, 32'h10, 32'hAAAA5555, 4'hF, -1, 1, rd, len);
      xfer(0, 0, 32'h10, 0, 0, -1, 0, rd, len);
      check("lit_rst_at_completion", 0, rd, 32'h0);
      xfer(0, 0, 32'h08, 0, 0, -1, 0, rd, len);
      check("lit_rst_clears_mem", 0, rd, 32'h0);
      idle(0, 2);

      // ---- WAIT_CYCLES = 3 instance: directed ----
      xfer(1, 1, 32'h08, 32'hDEADBEEF, 4'hF, -1, 0, rd, len);
      xfer(1, 0, 32'h08, 0, 0, -1, 0, rd, len);
      check("lit_wait3_len", 1, len, 5);
      check("lit_wait3_rd", 1, rd, 32'hDEADBEEF);
      xfer(1, 1, 32'h04, 32'hCAFEF00D, 4'hF, -1, 0, rd, len);
      xfer(1, 0, 32'h04, 0, 0, -1, 0, rd, len);
      check("lit_b2b_rd", 1, rd, 32'hCAFEF00D);
      xfer(1, 1, 32'h04, 32'h12345678, 4'hF, 2, 0, rd, len);
      check("lit_wait3_abort_len", 1, len, 0);
      xfer(1, 0, 32'h04, 0, 0, -1, 0, rd, len);
      check("lit_wait3_abort_unchanged", 1, rd, 32'hCAFEF00D);
      idle(1, 1);

      // ---- randomized traffic on both instances ----
      for (int k = 0; k < 2; k++) begin
         for (int t = 0; t < 150; t++) begin
            int          r;
            logic [31:0] a;
            int          ab;
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = 32'($urandom_range(0, DEP-1)) << 2;
            else if (r == 7) a = 32'($urandom_range(0, DEP*4-1)) | 32'h1;
            else             a = 32'($urandom_range(DEP, DEP+8)) << 2;
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, wait_of(k))) : -1;
            xfer(k, 1'($urandom), a, $urandom, 4'($urandom), ab, 0, rd, len);
            if ($urandom_range(0, 2) == 0) idle(k, int'($urandom_range(1, 2)));
         end
         idle(k, 1);
      end

      run = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
